// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: sequential AXI4-Lite reads into a show-ahead prefetch FIFO,
// with redirect/flush and halt-on-bus-error.
module ifu_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_ins,
    output logic            out_err,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready
);
    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam int unsigned   CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] fetch_pc;
    logic            halted;
    logic            drop_pend;

    logic [XLEN-1:0] fifo_pc  [DEPTH];
    logic [XLEN-1:0] fifo_ins [DEPTH];
    logic            fifo_err [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            empty;
    logic            issue;
    logic            push;
    logic            pop;
    logic            beat_err;

    // A request is only issued with a free slot, so a push can never overflow.
    assign empty    = (count == '0);
    assign issue    = (state == IDLE) && !halted && (count < FULL) && !redirect_valid;
    assign push     = (state == DATA) && rvalid && !redirect_valid;
    assign pop      = !empty && out_ready && !redirect_valid;
    assign beat_err = (rresp != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A beat arriving with a redirect is already consumed, so DATA returns to IDLE then.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (issue) state_next = ADDR;
            ADDR: if (arready) state_next = (drop_pend || redirect_valid) ? DROP : DATA;
            DATA: begin
                if (rvalid) begin
                    state_next = IDLE;
                end else if (redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: if (rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        arvalid = (state == ADDR);
        rready  = (state == DATA) || (state == DROP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            araddr <= '0;
        end else if (issue) begin
            araddr <= fetch_pc;
        end
    end

    // drop_pend remembers a redirect seen while the address is still waiting for arready.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            halted    <= 1'b0;
            drop_pend <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                halted   <= 1'b0;
            end else if (push) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                if (beat_err) halted <= 1'b1;
            end
            drop_pend <= (state == ADDR) && !arready && (drop_pend || redirect_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]  <= araddr;
            fifo_ins[wr_ptr] <= rdata;
            fifo_err[wr_ptr] <= beat_err;
        end
    end

    assign out_valid = !empty;
    assign out_pc    = fifo_pc[rd_ptr];
    assign out_ins   = fifo_ins[rd_ptr];
    assign out_err   = !empty && fifo_err[rd_ptr];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: AXI-Lite slave model, queue-based reference of the FIFO
// contents and fetch PC, and directed scenarios with literal expectations.
module tb_ifu_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic        out_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    ifu_prefetch #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_ins(out_ins), .out_err(out_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        err;
    } ent_t;

    int          n_cmp;
    int          n_fail;
    ent_t        q[$];
    ent_t        pop_log[$];
    logic [31:0] ar_log[$];

    logic [31:0] m_pc;
    bit          m_halt, m_wait_r, m_stale, live;
    bit          p_arvalid, p_arready, p_can_issue;
    logic [31:0] p_araddr;
    bit          ar_hs, r_hs;

    int          ar_delay, r_delay, ar_cnt, r_cnt;
    bit          r_pend;
    logic [31:0] r_addr, err_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (pop_log.size() < n) begin
            n_fail++;
            $display("FAIL %s: timeout, got %0d pops, want %0d", name, pop_log.size(), n);
        end
    endtask

    task automatic wait_high(input bit use_rready, input int budget, input string name);
        int k = 0;
        while (((use_rready ? rready : arvalid) !== 1'b1) && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if ((use_rready ? rready : arvalid) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: timeout, got 0, want 1", name);
        end
    endtask

    task automatic do_reset(input int ad, input int rd, input logic ordy);
        rst = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_b("rst_arvalid", arvalid, 1'b0);
        check_b("rst_rready", rready, 1'b0);
        check_w("rst_araddr", araddr, 32'h0);
        check_b("rst_out_valid", out_valid, 1'b0);
        check_b("rst_out_err", out_err, 1'b0);
        ar_delay = ad;
        r_delay = rd;
        ar_log.delete();
        pop_log.delete();
        out_ready = ordy;
        rst = 1'b0;
    endtask

    // Slave + reference model: evaluated at the falling edge for the upcoming rising edge.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        live = 1'b0; r_pend = 1'b0; ar_cnt = 0; r_cnt = 0; r_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 1'b0; rvalid = 1'b0; r_pend = 1'b0; ar_cnt = 0;
                q.delete();
                m_pc = RESET_PC; m_halt = 1'b0; m_wait_r = 1'b0; m_stale = 1'b0;
                p_arvalid = 1'b0; p_arready = 1'b0; p_can_issue = 1'b0; p_araddr = '0;
                live = 1'b1;
            end else if (live) begin
                check_b("out_valid", out_valid, q.size() != 0);
                if (q.size() != 0) begin
                    check_w("out_pc", out_pc, q[0].pc);
                    check_w("out_ins", out_ins, q[0].ins);
                    check_b("out_err", out_err, q[0].err);
                end else begin
                    check_b("out_err_empty", out_err, 1'b0);
                end
                check_b("rready_window", rready, m_wait_r);
                if (p_arvalid && !p_arready) begin
                    check_b("arvalid_hold", arvalid, 1'b1);
                    check_w("araddr_hold", araddr, p_araddr);
                end
                if (arvalid && !p_arvalid) begin
                    check_w("issue_pc", araddr, m_pc);
                    check_b("issue_allowed", p_can_issue, 1'b1);
                end

                rvalid = 1'b0;
                if (r_pend) begin
                    if (r_cnt > 0) begin
                        r_cnt--;
                    end else begin
                        rvalid = 1'b1;
                        rdata  = mem_word(r_addr);
                        rresp  = (r_addr == err_addr) ? 2'b10 : 2'b00;
                    end
                end
                arready = 1'b0;
                if (arvalid) begin
                    if (ar_cnt < ar_delay) ar_cnt++;
                    else arready = 1'b1;
                end

                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                p_can_issue = !m_halt && (q.size() < DEPTH);
                if (ar_hs) ar_log.push_back(araddr);
                if (out_valid && out_ready && !redirect_valid)
                    pop_log.push_back('{pc: out_pc, ins: out_ins, err: out_err});

                if (redirect_valid) begin
                    q.delete();
                    m_pc = redirect_pc;
                    m_halt = 1'b0;
                    m_stale = (arvalid || m_wait_r) && !r_hs;
                end else begin
                    if (out_ready && q.size() != 0) void'(q.pop_front());
                    if (r_hs && !m_stale) begin
                        q.push_back('{pc: r_addr, ins: rdata, err: (rresp != 2'b00)});
                        m_pc = m_pc + 32'd4;
                        if (rresp != 2'b00) m_halt = 1'b1;
                    end
                end
                if (r_hs) begin
                    m_wait_r = 1'b0;
                    m_stale = 1'b0;
                    r_pend = 1'b0;
                end
                if (ar_hs) begin
                    m_wait_r = 1'b1;
                    r_pend = 1'b1;
                    r_addr = araddr;
                    r_cnt = r_delay;
                    ar_cnt = 0;
                end
                p_arvalid = arvalid;
                p_arready = arready;
                p_araddr = araddr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        ar_delay = 0; r_delay = 0; err_addr = 32'h1;

        // Basic fetch and first-entry latency
        do_reset(0, 0, 1'b1);
        tick(); tick();
        check_b("lat_early", out_valid, 1'b0);
        tick();
        check_b("lat_first", out_valid, 1'b1);
        check_w("first_pc", out_pc, 32'h8000_0000);
        check_w("first_ins", out_ins, 32'h0000_C0DE);
        wait_pops(3, 40, "basic_pops");
        check_w("basic_ar0", ar_log[0], 32'h8000_0000);
        check_w("basic_ar1", ar_log[1], 32'h8000_0004);
        check_w("basic_ar2", ar_log[2], 32'h8000_0008);
        check_w("basic_ins1", pop_log[1].ins, 32'h0004_C0DE);
        check_w("basic_pc2", pop_log[2].pc, 32'h8000_0008);
        check_b("basic_err2", pop_log[2].err, 1'b0);

        // Fill, single pop, then push coinciding with pop at DEPTH-1
        do_reset(0, 0, 1'b0);
        repeat (40) tick();
        check_w("fill_reqs", 32'(ar_log.size()), 32'd4);
        check_b("fill_arvalid", arvalid, 1'b0);
        check_w("fill_head", out_pc, 32'h8000_0000);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        repeat (20) tick();
        check_w("refill_reqs", 32'(ar_log.size()), 32'd5);
        check_w("refill_addr", ar_log[4], 32'h8000_0010);
        check_w("refill_pops", 32'(pop_log.size()), 32'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tick(); tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check_w("pp_head", out_pc, 32'h8000_000C);
        repeat (20) tick();
        check_w("pp_reqs", 32'(ar_log.size()), 32'd7);
        check_w("pp_last", ar_log[6], 32'h8000_0018);

        // Slow slave
        do_reset(5, 7, 1'b1);
        wait_high(1'b0, 10, "slow_ar_wait");
        for (int i = 0; i < 5; i++) begin
            check_b("slow_arvalid", arvalid, 1'b1);
            check_w("slow_araddr", araddr, 32'h8000_0000);
            tick();
        end
        wait_pops(1, 40, "slow_pop");
        check_w("slow_pc", pop_log[0].pc, 32'h8000_0000);
        check_w("slow_ins", pop_log[0].ins, 32'h0000_C0DE);

        // Redirect while waiting for read data
        do_reset(0, 4, 1'b1);
        wait_high(1'b1, 10, "rdD_wait");
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check_b("rdD_empty", out_valid, 1'b0);
        wait_pops(1, 40, "rdD_pop");
        check_w("rdD_ar1", ar_log[1], 32'h8000_0100);
        check_w("rdD_pc", pop_log[0].pc, 32'h8000_0100);
        check_w("rdD_ins", pop_log[0].ins, 32'h0100_C0DE);

        // Redirect while the address is stalled
        do_reset(6, 0, 1'b1);
        wait_high(1'b0, 10, "rdA_wait");
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check_b("rdA_hold", arvalid, 1'b1);
        check_w("rdA_addr", araddr, 32'h8000_0000);
        wait_pops(1, 60, "rdA_pop");
        check_w("rdA_ar0", ar_log[0], 32'h8000_0000);
        check_w("rdA_ar1", ar_log[1], 32'h8000_0100);
        check_w("rdA_pc", pop_log[0].pc, 32'h8000_0100);

        // Bus error halts; redirect near the top of the address space wraps
        err_addr = 32'h8000_0008;
        do_reset(0, 0, 1'b1);
        wait_pops(3, 40, "err_pops");
        check_b("err_ok1", pop_log[1].err, 1'b0);
        check_w("err_pc", pop_log[2].pc, 32'h8000_0008);
        check_b("err_flag", pop_log[2].err, 1'b1);
        repeat (20) tick();
        check_w("halt_reqs", 32'(ar_log.size()), 32'd3);
        check_b("halt_arvalid", arvalid, 1'b0);
        err_addr = 32'h1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_pops(5, 40, "wrap_pops");
        check_w("wrap_pc0", pop_log[3].pc, 32'hFFFF_FFFC);
        check_w("wrap_ins0", pop_log[3].ins, 32'hFFFC_C0DE);
        check_w("wrap_pc1", pop_log[4].pc, 32'h0000_0000);
        check_b("wrap_err", pop_log[4].err, 1'b0);

        // Redirect in the same cycle as the read beat
        do_reset(0, 0, 1'b0);
        tick(); tick();
        check_b("rp_in_data", rready, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        check_b("rp_empty", out_valid, 1'b0);
        repeat (10) tick();
        check_w("rp_ar1", ar_log[1], 32'h8000_0200);
        check_b("rp_valid", out_valid, 1'b1);
        check_w("rp_head", out_pc, 32'h8000_0200);
        check_w("rp_ins", out_ins, 32'h0200_C0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
